// File: rtl/empacotador_duzias_if.sv
// Signal bundle between the dozen packer and the bottling line (sensor, box changer, counter).
// master = packer side, slave = line/environment side.
interface empacotador_duzias_if;
  logic       zera_contagem;
  logic       sensor_final;
  logic       caixa_ok;
  logic       pulso_duzia;
  logic       troca_caixa;
  logic       parar_esteira;
  logic [3:0] garrafas_na_caixa;
  logic       erro_timeout;

  modport master (
    input  zera_contagem,
    input  sensor_final,
    input  caixa_ok,
    output pulso_duzia,
    output troca_caixa,
    output parar_esteira,
    output garrafas_na_caixa,
    output erro_timeout
  );

  modport slave (
    output zera_contagem,
    output sensor_final,
    output caixa_ok,
    input  pulso_duzia,
    input  troca_caixa,
    input  parar_esteira,
    input  garrafas_na_caixa,
    input  erro_timeout
  );
endinterface

// File: rtl/empacotador_duzias.sv
// Debounces the final-position sensor, counts bottles into the current box, pulses once per
// dozen and runs the box-swap request/acknowledge handshake with a timeout.
module empacotador_duzias #(
  parameter logic [15:0] DEBOUNCE_CICLOS    = 16'd50000,
  parameter logic [3:0]  GARRAFAS_POR_DUZIA = 4'd12,
  parameter logic [31:0] TIMEOUT_CICLOS     = 32'd250000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  empacotador_duzias_if.master bus
);

  typedef enum logic [1:0] {
    CONTANDO = 2'd0,
    TROCA    = 2'd1,
    ERRO     = 2'd2
  } estado_t;

  logic        sync1_r;
  logic        sync2_r;
  logic        filt_r;
  logic        filt_prev_r;
  logic [15:0] deb_cnt_r;
  logic        evento_s;

  estado_t     estado_r;
  estado_t     estado_s;
  logic [3:0]  garrafas_r;
  logic [3:0]  garrafas_s;
  logic [31:0] timer_r;
  logic [31:0] timer_s;
  logic        pulso_r;
  logic        pulso_s;
  logic        troca_r;
  logic        troca_s;
  logic        parar_r;
  logic        parar_s;
  logic        erro_r;
  logic        erro_s;

  // Sensor synchronizer and debounce filter; deliberately untouched by zera_contagem.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r     <= 1'b0;
      sync2_r     <= 1'b0;
      filt_r      <= 1'b0;
      filt_prev_r <= 1'b0;
      deb_cnt_r   <= 16'd0;
    end else begin
      sync1_r     <= bus.sensor_final;
      sync2_r     <= sync1_r;
      filt_prev_r <= filt_r;
      if (sync2_r == filt_r) begin
        deb_cnt_r <= 16'd0;
      end else if (deb_cnt_r == DEBOUNCE_CICLOS) begin
        filt_r    <= sync2_r;
        deb_cnt_r <= 16'd0;
      end else begin
        deb_cnt_r <= deb_cnt_r + 16'd1;
      end
    end
  end

  assign evento_s = filt_r & ~filt_prev_r;

  // Next-state and next-output logic; outputs follow the next state so they are registered.
  always_comb begin
    estado_s   = estado_r;
    garrafas_s = garrafas_r;
    timer_s    = timer_r;
    pulso_s    = 1'b0;
    if (bus.zera_contagem) begin
      estado_s   = CONTANDO;
      garrafas_s = 4'd0;
      timer_s    = 32'd0;
    end else begin
      case (estado_r)
        CONTANDO: begin
          if (evento_s && (garrafas_r == (GARRAFAS_POR_DUZIA - 4'd1))) begin
            garrafas_s = GARRAFAS_POR_DUZIA;
            pulso_s    = 1'b1;
            timer_s    = 32'd0;
            estado_s   = TROCA;
          end else if (evento_s && (garrafas_r < (GARRAFAS_POR_DUZIA - 4'd1))) begin
            garrafas_s = garrafas_r + 4'd1;
          end else begin
            garrafas_s = garrafas_r;
          end
        end
        TROCA: begin
          // The acknowledge wins over a timeout landing in the same cycle.
          if (bus.caixa_ok) begin
            garrafas_s = 4'd0;
            timer_s    = 32'd0;
            estado_s   = CONTANDO;
          end else if (timer_r == (TIMEOUT_CICLOS - 32'd1)) begin
            estado_s = ERRO;
          end else begin
            timer_s = timer_r + 32'd1;
          end
        end
        ERRO: begin
          estado_s = ERRO;
        end
        default: begin
          estado_s   = CONTANDO;
          garrafas_s = 4'd0;
          timer_s    = 32'd0;
        end
      endcase
    end
    troca_s = (estado_s == TROCA);
    parar_s = (estado_s != CONTANDO);
    erro_s  = (estado_s == ERRO);
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_r   <= CONTANDO;
      garrafas_r <= 4'd0;
      timer_r    <= 32'd0;
      pulso_r    <= 1'b0;
      troca_r    <= 1'b0;
      parar_r    <= 1'b0;
      erro_r     <= 1'b0;
    end else begin
      estado_r   <= estado_s;
      garrafas_r <= garrafas_s;
      timer_r    <= timer_s;
      pulso_r    <= pulso_s;
      troca_r    <= troca_s;
      parar_r    <= parar_s;
      erro_r     <= erro_s;
    end
  end

  assign bus.pulso_duzia       = pulso_r;
  assign bus.troca_caixa       = troca_r;
  assign bus.parar_esteira     = parar_r;
  assign bus.garrafas_na_caixa = garrafas_r;
  assign bus.erro_timeout      = erro_r;

endmodule
